// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// status bit positions, frame shape and the transmit FSM state type.
package uart_pkg;

   localparam int unsigned REG_TXDATA = 0;
   localparam int unsigned REG_STATUS = 4;

   localparam int unsigned STAT_BUSY      = 0;
   localparam int unsigned STAT_FULL      = 1;
   localparam int unsigned STAT_EMPTY     = 2;
   localparam int unsigned STAT_OVERFLOW  = 3;
   localparam int unsigned STAT_IRQ_EN    = 4;
   localparam int unsigned STAT_COUNT_LSB = 5;
   localparam int unsigned STAT_COUNT_W   = 4;

   localparam int unsigned BITS_PER_FRAME = 10;
   localparam int unsigned DATA_BITS      = BITS_PER_FRAME - 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } txState_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; the head entry is presented combinationally on popData.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic                           pop,
   input  logic [WIDTH-1:0]               pushData,
   output logic [WIDTH-1:0]               popData,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned COUNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic             doPush;
   logic             doPop;

   assign doPush  = push && !full;
   assign doPop   = pop && !empty;
   assign full    = (count == COUNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign popData = mem[rdPtr];

   // Storage needs no reset; only the pointers and count define occupancy.
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: store decode, control/status registers,
// TX FIFO and the serialising FSM.
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        WE,
   input  logic [31:0] address,
   input  logic [31:0] WD,
   output logic        sel,
   output logic [31:0] RD,
   output logic        tx,
   output logic        irq
);

   localparam int unsigned BAUD_W  = $clog2(CLKS_PER_BIT);
   localparam int unsigned COUNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]        LAST_BIT    = 3'(DATA_BITS - 1);
   localparam logic [2:0]        STATUS_OFF  = 3'(REG_STATUS);

   txState_t          state;
   logic [BAUD_W-1:0] baudCnt;
   logic [2:0]        bitIdx;
   logic [7:0]        shiftReg;
   logic              overflow;
   logic              irqEn;

   logic               isStatus;
   logic               dataWrite;
   logic               ctrlWrite;
   logic               baudDone;
   logic               fifoPush;
   logic               fifoPop;
   logic [7:0]         fifoHead;
   logic               fifoFull;
   logic               fifoEmpty;
   logic [COUNT_W-1:0] fifoCount;
   logic [31:0]        statusWord;
   logic               unusedBits;

   assign sel        = (address[31:3] == BASE_ADDR[31:3]);
   assign isStatus   = (address[2] == STATUS_OFF[2]);
   assign dataWrite  = WE && sel && !isStatus;
   assign ctrlWrite  = WE && sel && isStatus;
   assign baudDone   = (baudCnt == BAUD_LAST);
   assign fifoPush   = dataWrite && !fifoFull;
   // The FSM takes the next byte either from idle or at the last stop-bit cycle.
   assign fifoPop    = !fifoEmpty && ((state == IDLE) || ((state == STOP) && baudDone));
   assign irq        = fifoEmpty && (state == IDLE) && irqEn;
   assign unusedBits = ^{WD[31:8], address[1:0]};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fifoPush),
      .pop      (fifoPop),
      .pushData (WD[7:0]),
      .popData  (fifoHead),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .count    (fifoCount)
   );

   always_comb begin
      statusWord                                      = '0;
      statusWord[STAT_BUSY]                           = (state != IDLE);
      statusWord[STAT_FULL]                           = fifoFull;
      statusWord[STAT_EMPTY]                          = fifoEmpty;
      statusWord[STAT_OVERFLOW]                       = overflow;
      statusWord[STAT_IRQ_EN]                         = irqEn;
      statusWord[STAT_COUNT_LSB +: STAT_COUNT_W]      = STAT_COUNT_W'(fifoCount);
   end

   always_comb begin
      RD = '0;
      if (sel && isStatus) RD = statusWord;
   end

   // Control registers and transmit FSM; tx is driven straight from this flop.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         baudCnt  <= '0;
         bitIdx   <= '0;
         shiftReg <= '0;
         tx       <= 1'b1;
         overflow <= 1'b0;
         irqEn    <= 1'b0;
      end else begin
         if (dataWrite && fifoFull)                   overflow <= 1'b1;
         else if (ctrlWrite && WD[STAT_OVERFLOW])     overflow <= 1'b0;
         if (ctrlWrite) irqEn <= WD[STAT_IRQ_EN];

         case (state)
            IDLE: begin
               baudCnt <= '0;
               if (fifoPop) begin
                  shiftReg <= fifoHead;
                  tx       <= 1'b0;
                  state    <= START;
               end
            end
            START: begin
               if (baudDone) begin
                  baudCnt <= '0;
                  bitIdx  <= '0;
                  tx      <= shiftReg[0];
                  state   <= DATA;
               end else begin
                  baudCnt <= baudCnt + 1'b1;
               end
            end
            DATA: begin
               if (baudDone) begin
                  baudCnt <= '0;
                  if (bitIdx == LAST_BIT) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bitIdx   <= bitIdx + 3'd1;
                     tx       <= shiftReg[1];
                     shiftReg <= {1'b0, shiftReg[7:1]};
                  end
               end else begin
                  baudCnt <= baudCnt + 1'b1;
               end
            end
            STOP: begin
               if (baudDone) begin
                  baudCnt <= '0;
                  if (fifoPop) begin
                     shiftReg <= fifoHead;
                     tx       <= 1'b0;
                     state    <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baudCnt <= baudCnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
